// File: rtl/dest_tracker.sv
// Master-side request issue stage with an in-order tracking FIFO of outstanding destinations.
// Optional reply/source comparison is compiled in with DEST_TRACKER_CHECK_EN.
module dest_tracker #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int DEPTH            = 12
) (
    input  logic                          clk,
    input  logic                          preset_full,
    input  logic [ADDRESS_WIDTH-1:0]      i_dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0]   i_vc_in,
    input  logic                          i_valid_in,
    output logic                          i_ready_out,
    output logic [ADDRESS_WIDTH-1:0]      o_dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]   o_vc_out,
    output logic                          o_valid_out,
    input  logic                          o_ready_in,
    input  logic [ADDRESS_WIDTH-1:0]      r_src_in,
    input  logic [VC_ADDRESS_WIDTH-1:0]   r_vc_in,
    input  logic                          r_valid_in,
    output logic [$clog2(DEPTH+1)-1:0]    o_pending_out,
    output logic                          r_err_out,
    output logic                          r_underflow_out
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = ADDRESS_WIDTH + VC_ADDRESS_WIDTH;

    logic [EW-1:0]               mem_q [DEPTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               pending_q, pending_d;
    logic                        valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0]    dst_q, dst_d;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
    logic                        err_q, err_d;
    logic                        uf_q, uf_d;

    logic          accept, empty, pop, underflow, mismatch;
    logic [EW-1:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready is held low while reset is asserted even though the registers already read zero.
    assign i_ready_out = ~preset_full & (~valid_q | o_ready_in) & (pending_q != CW'(DEPTH));
    assign accept      = i_valid_in & i_ready_out;
    assign empty       = (pending_q == '0);
    assign pop         = r_valid_in & ~empty;
    assign underflow   = r_valid_in & empty;
    assign head        = mem_q[rd_ptr_q];

`ifdef DEST_TRACKER_CHECK_EN
    assign mismatch = pop & (head != {r_src_in, r_vc_in});
`else
    logic unused_reply;
    assign unused_reply = ^{r_src_in, r_vc_in, head};
    assign mismatch     = 1'b0;
`endif

    always_comb begin
        pending_d = pending_q + CW'(accept) - CW'(pop);
        wr_ptr_d  = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        valid_d   = valid_q;
        dst_d     = dst_q;
        vc_d      = vc_q;
        if (accept) begin
            valid_d = 1'b1;
            dst_d   = i_dst_in;
            vc_d    = i_vc_in;
        end else if (o_ready_in) begin
            valid_d = 1'b0;
        end
        err_d = underflow | mismatch;
        uf_d  = uf_q | underflow;
    end

    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            dst_q     <= '0;
            vc_q      <= '0;
            err_q     <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            if (accept) mem_q[wr_ptr_q] <= {i_dst_in, i_vc_in};
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            dst_q     <= dst_d;
            vc_q      <= vc_d;
            err_q     <= err_d;
            uf_q      <= uf_d;
        end
    end

    assign o_valid_out     = valid_q;
    assign o_dst_out       = dst_q;
    assign o_vc_out        = vc_q;
    assign o_pending_out   = pending_q;
    assign r_err_out       = err_q;
    assign r_underflow_out = uf_q;
endmodule

// File: tb/tb_dest_tracker.sv
// Directed plus randomized bench for dest_tracker against a queue-based reference model.
module tb_dest_tracker;
    logic       clk = 1'b0;
    logic       preset_full = 1'b1;
    logic [3:0] i_dst_in = '0;
    logic       i_vc_in = 1'b0;
    logic       i_valid_in = 1'b0;
    logic       i_ready_out;
    logic [3:0] o_dst_out;
    logic       o_vc_out;
    logic       o_valid_out;
    logic       o_ready_in = 1'b0;
    logic [3:0] r_src_in = '0;
    logic       r_vc_in = 1'b0;
    logic       r_valid_in = 1'b0;
    logic [3:0] o_pending_out;
    logic       r_err_out;
    logic       r_underflow_out;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_q[$];
    bit         m_ov = 0;
    logic [3:0] m_od = '0;
    logic       m_ovc = 1'b0;
    bit         m_err = 0;
    bit         m_uf = 0;

    always #5 clk = ~clk;

    dest_tracker #(.ADDRESS_WIDTH(4), .VC_ADDRESS_WIDTH(1), .DEPTH(12)) dut (
        .clk(clk), .preset_full(preset_full),
        .i_dst_in(i_dst_in), .i_vc_in(i_vc_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
        .o_dst_out(o_dst_out), .o_vc_out(o_vc_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
        .r_src_in(r_src_in), .r_vc_in(r_vc_in), .r_valid_in(r_valid_in),
        .o_pending_out(o_pending_out), .r_err_out(r_err_out), .r_underflow_out(r_underflow_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("o_valid", o_valid_out, m_ov);
        chk("o_dst", o_dst_out, m_od);
        chk("o_vc", o_vc_out, m_ovc);
        chk("pending", o_pending_out, m_q.size());
        chk("err", r_err_out, m_err);
        chk("underflow", r_underflow_out, m_uf);
    endtask

    // One clock of stimulus: drive, check combinational ready, advance model, check registered outputs.
    task automatic step(input bit v, input logic [3:0] d, input logic vc, input bit rdy,
                        input bit rv, input logic [3:0] s, input logic rvc);
        bit exp_rdy, acc;
        logic [4:0] h;
        i_valid_in = v; i_dst_in = d; i_vc_in = vc; o_ready_in = rdy;
        r_valid_in = rv; r_src_in = s; r_vc_in = rvc;
        #1;
        exp_rdy = (!m_ov || rdy) && (m_q.size() < 12);
        chk("ready", i_ready_out, exp_rdy);
        acc = v && exp_rdy;
        m_err = 0;
        if (rv) begin
            if (m_q.size() == 0) begin
                m_uf = 1;
                m_err = 1;
            end else begin
                h = m_q.pop_front();
`ifdef DEST_TRACKER_CHECK_EN
                if (h != {s, rvc}) m_err = 1;
`endif
            end
        end
        if (acc) begin
            m_q.push_back({d, vc});
            m_ov = 1; m_od = d; m_ovc = vc;
        end else if (rdy) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic reply_head(input bit v, input logic [3:0] d, input logic vc);
        logic [4:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 5'd0;
        step(v, d, vc, 1, 1, h[4:1], h[0]);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && m_q.size() > 0; i++) reply_head(0, 0, 0);
    endtask

    initial begin
        logic [4:0] h;
        #1;
        chk("rst_ready", i_ready_out, 0);
        chk_all();
        @(negedge clk);
        preset_full = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_ready", i_ready_out, 1);

        // three accepts
        step(1, 4'd3, 1, 1, 0, 0, 0);
        chk("seq0", o_dst_out, 3);
        step(1, 4'd5, 0, 1, 0, 0, 0);
        chk("seq1", o_dst_out, 5);
        step(1, 4'd9, 1, 1, 0, 0, 0);
        chk("seq2", o_dst_out, 9);
        chk("pend3", o_pending_out, 3);
        drain();

        // fill to DEPTH, then one reply
        for (int i = 0; i < 12; i++) step(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("full_ready", i_ready_out, 0);
        chk("full_pend", o_pending_out, 12);
        reply_head(0, 0, 0);
        chk("refill_ready", i_ready_out, 1);
        chk("refill_pend", o_pending_out, 11);
        drain();

        // backpressure
        step(1, 4'd7, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0);
            chk("bp_hold", o_dst_out, 7);
        end
        step(1, 4'd8, 0, 1, 0, 0, 0);
        chk("bp_resume", o_dst_out, 8);
        drain();

        // mismatching reply
        step(1, 4'd5, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 4'd6, 0);
`ifdef DEST_TRACKER_CHECK_EN
        chk("mismatch_err", r_err_out, 1);
`else
        chk("mismatch_err", r_err_out, 0);
`endif
        step(0, 0, 0, 1, 0, 0, 0);
        chk("err_pulse_end", r_err_out, 0);

        // underflow
        step(0, 0, 0, 1, 1, 4'd2, 1);
        chk("uf_err", r_err_out, 1);
        chk("uf_sticky", r_underflow_out, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("uf_hold", r_underflow_out, 1);

        // same-cycle accept and reply at pending 2, then 20 pairs
        step(1, 4'd1, 0, 1, 0, 0, 0);
        step(1, 4'd2, 1, 1, 0, 0, 0);
        reply_head(1, 4'd3, 0);
        chk("same_pend", o_pending_out, 2);
        for (int i = 0; i < 20; i++) reply_head(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        // random traffic
        for (int i = 0; i < 300; i++) begin
            h = (m_q.size() > 0 && $urandom_range(0, 4) != 0) ? m_q[0] : 5'($urandom_range(0, 31));
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, h[4:1], h[0]);
        end

        // mid-stream reset
        step(1, 4'd11, 1, 1, 0, 0, 0);
        i_valid_in = 0; o_ready_in = 0; r_valid_in = 0;
        #2;
        preset_full = 1'b1;
        #1;
        m_q.delete();
        m_ov = 0; m_od = 0; m_ovc = 0; m_err = 0; m_uf = 0;
        chk("midrst_ready", i_ready_out, 0);
        chk_all();
        @(negedge clk);
        preset_full = 1'b0;
        @(posedge clk);
        #1;
        chk_all();
        step(1, 4'd4, 1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dest_tracker.md
# dest_tracker

Master-side counterpart of the slave-side return-destination queue: drives requests from a master into the NoC and tracks every outstanding request until its reply returns. Each accepted request's destination router and VC go into an in-order tracking FIFO. The outstanding count throttles the master at DEPTH. Each returning reply pops the FIFO and is checked against the expected source.

## Interface
- ADDRESS_WIDTH, 4, router address width
- VC_ADDRESS_WIDTH, 1, VC index width
- DEPTH, 12, maximum outstanding requests; must be ≥ 2 (CW = $clog2(DEPTH+1))

Ports:
- clk  input  1  clock, all state rising-edge
- preset_full  input  1  reset: asynchronous, active-high
- i_dst_in  input  ADDRESS_WIDTH  request destination from master
- i_vc_in  input  VC_ADDRESS_WIDTH  request VC from master
- i_valid_in  input  1  master request valid
- i_ready_out  output  1  block can accept request (combinational)
- o_dst_out  output  ADDRESS_WIDTH  registered destination to NoC
- o_vc_out  output  VC_ADDRESS_WIDTH  registered VC to NoC
- o_valid_out  output  1  registered request valid to NoC
- o_ready_in  input  1  NoC accepts request
- r_src_in  input  ADDRESS_WIDTH  source router of returning reply
- r_vc_in  input  VC_ADDRESS_WIDTH  VC of returning reply
- r_valid_in  input  1  reply valid (one per cycle, no backpressure)
- o_pending_out  output  CW  outstanding requests (issued, reply not yet seen)
- r_err_out  output  1  registered one-cycle error pulse
- r_underflow_out  output  1  sticky: reply arrived with no outstanding request

## Operation
- Accept: i_valid_in & i_ready_out.
- i_ready_out = (~o_valid_out | o_ready_in) & (o_pending_out != DEPTH).
- On accept:
  - output stage loads {i_dst_in, i_vc_in} and sets o_valid_out;
  - tracking FIFO pushes {i_dst_in, i_vc_in};
  - pending count increments.
- Output stage holds o_dst_out, o_vc_out and o_valid_out stable while o_valid_out & ~o_ready_in.
- o_valid_out clears when o_ready_in is high and there is no new accept.
- Reply (r_valid_in) with pending ≠ 0:
  - FIFO pops the head;
  - pending count decrements;
  - head is compared with {r_src_in, r_vc_in} (compare only; see Configuration).
- Reply with pending = 0:
  - no pop, count stays 0;
  - r_underflow_out sets and stays set until reset;
  - r_err_out pulses.
- Same-cycle accept and reply:
  - pop uses the head before the push;
  - count is unchanged.
- Reply in the same cycle as the push of the only entry (pending = 0 before the edge) is an underflow; the push still occurs.
- FIFO:
  - binary read/write pointers modulo DEPTH; wrap DEPTH-1 → 0;
  - full/empty derived from the pending count only;
  - non-power-of-2 DEPTH is supported.
- Pending count is never negative and never exceeds DEPTH (guaranteed by i_ready_out gating).

## Timing
- Reset (preset_full high, asynchronous), every register cleared:
  - o_valid_out = 0, o_dst_out = 0, o_vc_out = 0;
  - o_pending_out = 0, r_err_out = 0, r_underflow_out = 0;
  - FIFO pointers = 0.
- During reset i_ready_out = 0; it rises combinationally after release if pending is 0.
- Reset mid-operation: all outstanding entries are discarded, and an in-flight o_valid_out drops immediately.
- Latency:
  - request accept → o_valid_out: 1 cycle;
  - reply → r_err_out: 1 cycle, high for exactly 1 cycle per offending reply;
  - o_pending_out updates the cycle after accept or reply.
- Throughput: 1 request/cycle while o_ready_in is high and pending < DEPTH; 1 reply/cycle always.
- Full boundary:
  - at pending = DEPTH, i_ready_out = 0 in the same cycle;
  - a reply at full re-enables i_ready_out the next cycle (after the count update, not combinationally).

## Configuration
- DEST_TRACKER_CHECK_EN defined:
  - comparison of the FIFO head with {r_src_in, r_vc_in} is compiled in;
  - a mismatch pulses r_err_out; underflow also pulses it.
- Not defined:
  - comparator removed;
  - r_err_out pulses only on underflow;
  - FIFO, counter and r_underflow_out behaviour are identical.

## Test plan
- Reset, then 3 accepts (dst 3/vc 1, dst 5/vc 0, dst 9/vc 1) with o_ready_in = 1 → o_dst_out sequence 3, 5, 9 one cycle after each accept; o_pending_out = 3.
- DEPTH = 12; 12 accepts and no replies → i_ready_out = 0 with pending = 12; one reply → i_ready_out = 1 the next cycle, pending = 11.
- o_ready_in = 0 for 4 cycles with o_valid_out = 1 → o_dst_out and o_vc_out stable, i_ready_out = 0, no FIFO push; o_ready_in = 1 → next accept proceeds.
- With DEST_TRACKER_CHECK_EN defined, pending {dst 5, vc 0}, reply {src 6, vc 0} → r_err_out = 1 for one cycle, pending decrements. Without the macro → r_err_out stays 0.
- Reply at pending = 0 → r_err_out pulses, r_underflow_out = 1 and stays set; pending stays 0.
- Same-cycle accept and reply at pending = 2 → pending stays 2 and the head pops in order. Then 20 push/pop pairs → pointer wrap with no ordering error. Assert preset_full mid-stream → all outputs 0 immediately.
